uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, receive FIFO entries; power of 2, minimum 2.
REQ-004 SHALL have port clk_i  input  1  system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_i  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port uart_rxd  input  1  serial receive line, asynchronous to clk_i, idle high.
REQ-007 SHALL have port rd_en_i  input  1  bus read strobe; pops one byte per cycle when the FIFO is non-empty.
REQ-008 SHALL have port clr_err_i  input  1  clears the sticky error flags.
REQ-009 SHALL have port rx_data_o  output  8  FIFO head byte, first-word fall-through.
REQ-010 SHALL have port rx_valid_o  output  1  FIFO non-empty.
REQ-011 SHALL have port rx_count_o  output  $clog2(FIFO_DEPTH)+1  number of bytes held.
REQ-012 SHALL have port rx_overrun_o  output  1  sticky flag: a byte was dropped because the FIFO was full.
REQ-013 SHALL have port rx_frame_err_o  output  1  sticky flag: a stop bit was sampled low.
REQ-014 SHALL have port rx_parity_err_o  output  1  sticky flag: a parity mismatch was detected; tied 0 when UART_RX_PARITY_EN is undefined.

Function
REQ-015 SHALL pass uart_rxd through a 2-flop synchronizer; all decoding SHALL use the synchronized value.
REQ-016 SHALL set the bit period to DIV = CLK_FREQ/BAUD_RATE cycles, integer division; 434 at the defaults.
REQ-017 SHALL implement an FSM with states IDLE, START, DATA, PARITY (present only when the macro is defined), STOP and BREAK.
REQ-018 IDLE: a synchronized 1->0 transition SHALL move the FSM to START and clear the baud counter.
REQ-019 START: at count DIV/2, the FSM SHALL move to DATA if the line is low, or return to IDLE if it is high (glitch rejected).
REQ-020 DATA: the FSM SHALL sample every DIV cycles after the mid-start point and shift in 8 bits LSB first, then move to PARITY or STOP.
REQ-021 STOP: at the sample point, a high line SHALL cause a push of the byte and a move to IDLE.
REQ-022 STOP: at the sample point, a low line SHALL set rx_frame_err_o, discard the byte, and move to BREAK.
REQ-023 BREAK: the FSM SHALL stay until the line is sampled high, then move to IDLE.
REQ-024 A push SHALL be visible on rx_valid_o, rx_count_o and rx_data_o (when the FIFO was empty) exactly 1 cycle after the stop-bit sample edge.
REQ-025 A push while the FIFO is full and rd_en_i is low SHALL drop the new byte, leave contents unchanged, and set rx_overrun_o.
REQ-026 A simultaneous push and pop while full SHALL accept both: count unchanged, no overrun.
REQ-027 A simultaneous push and pop while empty SHALL ignore the pop and accept the push, giving count 1.
REQ-028 rd_en_i while empty SHALL be ignored, with no pointer movement.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-030 clr_err_i SHALL clear all sticky flags next cycle; if an error event occurs in the same cycle, the set SHALL win.

Reset
REQ-031 Reset SHALL force FSM=IDLE, counters=0, FIFO empty, rx_valid_o=0, rx_count_o=0, rx_data_o=0x00, all error flags=0, and synchronizer flops=1.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no push; after release, reception SHALL resume at the next falling edge.

Configuration
REQ-033 With UART_RX_PARITY_EN defined, the frame SHALL be 8E1: PARITY samples 1 bit, and a mismatch against the even parity of the data SHALL set rx_parity_err_o and discard the byte, while the stop bit is still checked.
REQ-034 Without UART_RX_PARITY_EN, the frame SHALL be 8N1: no PARITY state, and rx_parity_err_o SHALL be constant 0.

Structure
REQ-035 Shared include uart_param.v SHALL hold the default CLK_FREQ/BAUD_RATE constants and the FSM state encodings, shared with the existing transmitter.
REQ-036 The FIFO SHALL be a sub-module uart_rx_fifo (parameter DEPTH, width 8, with push, pop, full, empty and count).

Verification
REQ-037 Bench SHALL cover: defaults, send 0x55 -> 1 cycle after stop sample: rx_valid_o=1, rx_data_o=0x55, rx_count_o=1; rd_en_i pulse -> rx_valid_o=0.
REQ-038 Bench SHALL cover: send 0x00..0x08 with no reads -> rx_count_o=8, rx_overrun_o=1; 8 reads return 0x00..0x07 and 0x08 is absent.
REQ-039 Bench SHALL cover: send 0xA5 with the stop bit held low for 2 bit times -> rx_frame_err_o=1, rx_count_o=0; then 0x3C -> received correctly; clr_err_i -> flag=0.
REQ-040 Bench SHALL cover: a 100-cycle low glitch on an idle line -> no push and FSM back in IDLE; a following 0xF0 is received intact.
REQ-041 Bench SHALL cover: rst_i low during bit 4 of 0x81 -> no byte; a following 0x7E -> rx_data_o=0x7E.
REQ-042 Bench SHALL cover, with UART_RX_PARITY_EN: 0x03 sent with parity bit 1 -> rx_parity_err_o=1, no push; parity bit 0 -> 0x03 received.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// UART receiver package: default rates, FSM state type, parity helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a. PARITY state exists only when UART_RX_PARITY_EN is defined.
`include "uart_param.v"

package uart_rx_pkg;

    localparam int DEFAULT_CLK_FREQ  = `UART_CLK_FREQ;
    localparam int DEFAULT_BAUD_RATE = `UART_BAUD_RATE;

    typedef enum logic [2:0] {
        ST_IDLE   = `UART_ST_IDLE,
        ST_START  = `UART_ST_START,
        ST_DATA   = `UART_ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = `UART_ST_PARITY,
`endif
        ST_STOP   = `UART_ST_STOP,
        ST_BREAK  = `UART_ST_BREAK
    } rxState_t;

    // Even parity bit that makes the total number of ones even.
    function automatic logic evenParity(input logic [7:0] dat);
        return ^dat;
    endfunction

endpackage

// File: rtl/uart_param.v
// Shared UART constants: default clock/baud and the receive/transmit FSM state codes.
// Latency: n/a (text macros only).
// Backpressure: n/a.
`ifndef UART_PARAM_V
`define UART_PARAM_V

`define UART_CLK_FREQ    50000000
`define UART_BAUD_RATE   115200

`define UART_ST_IDLE     3'd0
`define UART_ST_START    3'd1
`define UART_ST_DATA     3'd2
`define UART_ST_PARITY   3'd3
`define UART_ST_STOP     3'd4
`define UART_ST_BREAK    3'd5

`endif

// File: rtl/uart_rx_fifo.sv
// Byte FIFO with first-word fall-through head, occupancy count and full/empty flags.
// Latency: a push is visible on popDat/empty/count the cycle after the push edge.
// Backpressure: push while full is dropped unless a pop happens in the same cycle; pop while empty is ignored.
module uart_rx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      push,
    input  logic [7:0]                pushDat,
    input  logic                      pop,
    output logic [7:0]                popDat,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [AW:0]   cnt;
    logic          doPush;
    logic          doPop;

    assign full   = (cnt == (AW+1)'(DEPTH));
    assign empty  = (cnt == '0);
    assign count  = cnt;
    assign popDat = mem[rdPtr];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a concurrent push.
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);

    // Storage and write pointer; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wrPtr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (doPush) begin
            mem[wrPtr] <= pushDat;
            wrPtr      <= wrPtr + 1'b1;
        end
    end

    // Read pointer and occupancy.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdPtr <= '0;
            cnt   <= '0;
        end else begin
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver (8N1, or 8E1 with UART_RX_PARITY_EN) feeding a byte FIFO with sticky error flags.
// Latency: byte appears on rx_valid_o/rx_data_o/rx_count_o one cycle after the stop-bit sample edge.
// Backpressure: none on the line; a byte arriving to a full FIFO without a read is dropped and flags overrun.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
    parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           uart_rxd,
    input  logic                           rd_en_i,
    input  logic                           clr_err_i,
    output logic [7:0]                     rx_data_o,
    output logic                           rx_valid_o,
    output logic [$clog2(FIFO_DEPTH):0]    rx_count_o,
    output logic                           rx_overrun_o,
    output logic                           rx_frame_err_o,
    output logic                           rx_parity_err_o
);

    localparam int DIV  = CLK_FREQ / BAUD_RATE;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);

    rxState_t      state;
    rxState_t      stateNext;
    logic          sync1;
    logic          sync2;
    logic          rxSync;
    logic [1:0]    warm;
    logic          rxPrev;
    logic          lineFall;
    logic [CW-1:0] baudCnt;
    logic [2:0]    bitIdx;
    logic [7:0]    shiftReg;
    logic          midStart;
    logic          bitTick;
    logic          cntClr;
    logic          cntRun;
    logic          pushVld;
    logic          frameErrSet;
    logic          overrunSet;
    logic          fifoFull;
    logic          fifoEmpty;

    assign rxSync   = sync2;
    assign lineFall = rxPrev && !rxSync;
    assign midStart = (baudCnt == CW'(HALF));
    assign bitTick  = (baudCnt == CW'(DIV - 1));

    // Two-flop synchronizer for the asynchronous line, idle-high at reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= uart_rxd;
            sync2 <= sync1;
        end
    end

    // Edge-detect history; held low until the synchronizer carries real line data, so a line
    // that is already low when reset releases does not look like a start bit.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            warm   <= '0;
            rxPrev <= 1'b0;
        end else begin
            warm   <= {warm[0], 1'b1};
            rxPrev <= warm[1] ? rxSync : 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // FSM next-state logic.
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE:   if (lineFall) stateNext = ST_START;
            ST_START:  if (midStart) stateNext = rxSync ? ST_IDLE : ST_DATA;
`ifdef UART_RX_PARITY_EN
            ST_DATA:   if (bitTick && bitIdx == 3'd7) stateNext = ST_PARITY;
            ST_PARITY: if (bitTick) stateNext = ST_STOP;
`else
            ST_DATA:   if (bitTick && bitIdx == 3'd7) stateNext = ST_STOP;
`endif
            ST_STOP:   if (bitTick) stateNext = rxSync ? ST_IDLE : ST_BREAK;
            ST_BREAK:  if (rxSync) stateNext = ST_IDLE;
            default:   stateNext = ST_IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    logic parityBad;
    logic parityErrSet;
    logic parityFlag;

    // Parity is judged at its own sample point; the byte is still held until the stop bit is checked.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            parityBad <= 1'b0;
        end else if (state == ST_PARITY && bitTick) begin
            parityBad <= (rxSync != evenParity(shiftReg));
        end
    end

    // Sticky parity flag; a new error wins over a clear in the same cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            parityFlag <= 1'b0;
        end else if (parityErrSet) begin
            parityFlag <= 1'b1;
        end else if (clr_err_i) begin
            parityFlag <= 1'b0;
        end
    end

    assign rx_parity_err_o = parityFlag;
`endif

    // FSM outputs: counter control, FIFO push and error events.
    always_comb begin
        cntClr      = (stateNext != state) || bitTick;
        cntRun      = (state == ST_START) || (state == ST_DATA) || (state == ST_STOP);
        frameErrSet = (state == ST_STOP) && bitTick && !rxSync;
`ifdef UART_RX_PARITY_EN
        cntRun       = cntRun || (state == ST_PARITY);
        parityErrSet = (state == ST_PARITY) && bitTick && (rxSync != evenParity(shiftReg));
        pushVld      = (state == ST_STOP) && bitTick && rxSync && !parityBad;
`else
        pushVld      = (state == ST_STOP) && bitTick && rxSync;
`endif
    end

`ifndef UART_RX_PARITY_EN
    assign rx_parity_err_o = 1'b0;
`endif

    // Baud counter and LSB-first data shifter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            baudCnt  <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
        end else begin
            if (cntClr) begin
                baudCnt <= '0;
            end else if (cntRun) begin
                baudCnt <= baudCnt + 1'b1;
            end
            if (state == ST_START) begin
                bitIdx <= '0;
            end else if (state == ST_DATA && bitTick) begin
                shiftReg <= {rxSync, shiftReg[7:1]};
                bitIdx   <= bitIdx + 3'd1;
            end
        end
    end

    assign overrunSet = pushVld && fifoFull && !rd_en_i;

    // Sticky overrun and framing flags; a new error wins over a clear in the same cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rx_overrun_o   <= 1'b0;
            rx_frame_err_o <= 1'b0;
        end else begin
            if (overrunSet) begin
                rx_overrun_o <= 1'b1;
            end else if (clr_err_i) begin
                rx_overrun_o <= 1'b0;
            end
            if (frameErrSet) begin
                rx_frame_err_o <= 1'b1;
            end else if (clr_err_i) begin
                rx_frame_err_o <= 1'b0;
            end
        end
    end

    uart_rx_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push    (pushVld),
        .pushDat (shiftReg),
        .pop     (rd_en_i),
        .popDat  (rx_data_o),
        .full    (fifoFull),
        .empty   (fifoEmpty),
        .count   (rx_count_o)
    );

    assign rx_valid_o = !fifoEmpty;

endmodule
